sprite_row_fetch: RTL and testbench
===================================

Name: sprite_row_fetch

Overview:
- Upstream feeder for the per-sprite pixel shift register.
- Each scanline, it checks whether the sprite covers the line about to be drawn and, if so, reads that sprite row from sprite ROM and parallel-loads it into the shift register.
- It then issues exactly NUM_WORDS shift enables, starting when the beam reaches the sprite's x position.
- On lines the sprite does not cover, it loads zeros so stale pixels never leak out.

Parameters:
- WORD_SIZE, 4: bits per pixel (colour index).
- NUM_WORDS, 16: pixels per sprite row; equals the shift register depth.
- SPRITE_ROWS, 16: rows per sprite frame.
- NUM_FRAMES, 4: animation frames stored in ROM.
- COORD_W, 11: width of screen coordinates.
- ROM_ADDR_W, 6: ROM address width; must be >= clog2(NUM_FRAMES*SPRITE_ROWS).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-clock enable; hcount advances once per pix_en
- hcount  in  COORD_W  current horizontal pixel position
- line_start  in  1  one-cycle pulse in horizontal blanking, before line `line_num` is drawn
- line_num  in  COORD_W  line about to be drawn; sampled on line_start
- sprite_on  in  1  sprite visible; sampled on line_start
- sprite_x  in  COORD_W  left edge of the sprite; sampled on line_start
- sprite_y  in  COORD_W  top edge of the sprite; sampled on line_start
- frame_sel  in  clog2(NUM_FRAMES)  animation frame; sampled on line_start
- rom_addr  out  ROM_ADDR_W  sprite ROM address (registered)
- rom_data  in  WORD_SIZE*NUM_WORDS  ROM row data, valid 1 clk after rom_addr
- sr_ld  out  1  shift register parallel-load strobe (registered, 1 clk)
- sr_data  out  WORD_SIZE*NUM_WORDS  shift register load data
- sr_en  out  1  shift register shift enable (combinational from state, pix_en and hcount)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; rom_addr 0; sr_ld 0; sr_data 0; sr_en 0; busy 0; pixel counter 0; latched coordinates 0.
- Reset has priority over every other input and aborts any state. sr_en is forced 0 in the reset cycle.
- Row calculation: row = line_num - sprite_y, computed at COORD_W+1 bits signed.
  - hit = sprite_on && row >= 0 && row < SPRITE_ROWS.
- ROM row layout: the leftmost pixel is in the most-significant word, because the shift register emits its top word first. sr_data passes rom_data through unmodified.
- States: IDLE, ADDR, WAIT, LOAD, ARMED, SHIFT.
- IDLE, on line_start:
  - Latch sprite_x.
  - On hit: rom_addr <= frame_sel*SPRITE_ROWS + row, then go to ADDR.
  - On miss: assert sr_ld next cycle with sr_data = 0, then return to IDLE.
- ADDR -> WAIT: 1 cycle, covering the ROM read latency.
- WAIT -> LOAD: capture rom_data into sr_data.
- LOAD: sr_ld = 1 for exactly this one cycle, then go to ARMED.
  - Total latency: sr_ld is high 4 clks after the line_start cycle (line_start at cycle T gives sr_ld at T+4).
- ARMED: when pix_en && hcount == latched x:
  - sr_en = 1 in that same cycle, counter <= 1, go to SHIFT.
  - pix_en low: hold state.
- SHIFT:
  - sr_en = pix_en; counter increments on each pix_en.
  - After the NUM_WORDS-th enable, return to IDLE.
  - sr_en is therefore high for exactly NUM_WORDS pix_en cycles, at hcount = x .. x+NUM_WORDS-1.
- sr_en is never asserted outside ARMED-match/SHIFT. sr_ld and sr_en are never high in the same cycle.
- line_start in a non-IDLE state: abort, then process it exactly as from IDLE in that same cycle (re-sample inputs, new fetch or zero-load). An in-progress shift stops immediately.
- sprite_x is never reached, e.g. x >= line width: remain ARMED until the next line_start.
- Partial sprite off the top (sprite_y > line_num): negative row, so miss, so zero-load.
- Bottom edge: row == SPRITE_ROWS-1 is a hit; row == SPRITE_ROWS is a miss.
- Input changes between line_start pulses are ignored; only the latched values are used.

Test Plan:
- Basic hit:
  - Stimulus: reset, then line_start with line_num=20, sprite_y=15, sprite_on=1, frame_sel=2, sprite_x=100.
  - Required: rom_addr = 2*16+5 = 37; sr_ld at T+4 with sr_data = ROM[37].
  - Required: sr_en high for exactly 16 pix_en cycles at hcount 100..115, then busy=0.
- Miss cases (line_num=14 with sprite_y=15; line_num=31 with sprite_y=15; sprite_on=0):
  - Required: rom_addr unchanged; sr_ld with sr_data=0 at T+1; no sr_en.
- Bottom edge: line_num=30, sprite_y=15.
  - Required: hit on row 15, rom_addr=47 with frame 2.
- Abort mid-shift:
  - Stimulus: line_start after 7 sr_en pulses.
  - Required: sr_en drops that cycle, a new fetch starts, and the fresh row gets a full 16 pulses.
- Gapped pixel clock: pix_en toggling 1/0.
  - Required: sr_en only on pix_en=1 cycles, still exactly 16 pulses, and all sr_en pulses follow sr_ld.
- Reset mid-operation: reset asserted during WAIT and during SHIFT.
  - Required: all outputs 0 next cycle, state IDLE, and no sr_ld/sr_en until the next line_start.

Source files
------------

// File: rtl/sprite_row_fetch.sv
// Per-scanline sprite row fetcher: picks the sprite row for the upcoming line,
// loads it (or zeros) into the pixel shift register, then paces NUM_WORDS shifts from sprite_x.
module sprite_row_fetch #(
  parameter int WORD_SIZE   = 4,
  parameter int NUM_WORDS   = 16,
  parameter int SPRITE_ROWS = 16,
  parameter int NUM_FRAMES  = 4,
  parameter int COORD_W     = 11,
  parameter int ROM_ADDR_W  = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pix_en,
  input  logic [COORD_W-1:0]                hcount,
  input  logic                              line_start,
  input  logic [COORD_W-1:0]                line_num,
  input  logic                              sprite_on,
  input  logic [COORD_W-1:0]                sprite_x,
  input  logic [COORD_W-1:0]                sprite_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]     frame_sel,
  output logic [ROM_ADDR_W-1:0]             rom_addr,
  input  logic [WORD_SIZE*NUM_WORDS-1:0]    rom_data,
  output logic                              sr_ld,
  output logic [WORD_SIZE*NUM_WORDS-1:0]    sr_data,
  output logic                              sr_en,
  output logic                              busy
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_ARMED, S_SHIFT
  } state_t;

  state_t                           r_state;
  logic [COORD_W-1:0]               r_x;
  logic [CNT_W-1:0]                 r_cnt;
  logic [ROM_ADDR_W-1:0]            r_rom_addr;
  logic                             r_sr_ld;
  logic [WORD_SIZE*NUM_WORDS-1:0]   r_sr_data;

  logic signed [COORD_W:0]          w_row;
  logic                             w_hit;
  logic [ROM_ADDR_W-1:0]            w_addr;
  logic                             w_match;
  logic                             w_shift;

  // Row select: one extra bit so a sprite starting below this line gives a negative row
  assign w_row  = $signed({1'b0, line_num}) - $signed({1'b0, sprite_y});
  assign w_hit  = sprite_on && !w_row[COORD_W] &&
                  (w_row[COORD_W-1:0] < COORD_W'(SPRITE_ROWS));
  assign w_addr = ROM_ADDR_W'(frame_sel) * ROM_ADDR_W'(SPRITE_ROWS) +
                  ROM_ADDR_W'(w_row[COORD_W-1:0]);

  // The load strobe lands in the first ARMED cycle, so the match is held off for it
  assign w_match = (r_state == S_ARMED) && !r_sr_ld && pix_en && (hcount == r_x);
  assign w_shift = (r_state == S_SHIFT) && pix_en;
  assign sr_en   = !reset && !line_start && (w_match || w_shift);

  assign rom_addr = r_rom_addr;
  assign sr_ld    = r_sr_ld;
  assign sr_data  = r_sr_data;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_sr_ld    <= 1'b0;
      r_sr_data  <= '0;
    end else begin
      r_sr_ld <= 1'b0;
      if (line_start) begin
        r_x   <= sprite_x;
        r_cnt <= '0;
        if (w_hit) begin
          r_rom_addr <= w_addr;
          r_state    <= S_ADDR;
        end else begin
          r_sr_ld   <= 1'b1;
          r_sr_data <= '0;
          r_state   <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE:  ;
          S_ADDR:  r_state <= S_WAIT;
          // ROM row is valid here, one clock after the registered address
          S_WAIT: begin
            r_sr_data <= rom_data;
            r_state   <= S_LOAD;
          end
          S_LOAD: begin
            r_sr_ld <= 1'b1;
            r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_match) begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (pix_en) begin
              if (r_cnt == CNT_W'(NUM_WORDS - 1)) begin
                r_cnt   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Directed bench for sprite_row_fetch: hits, misses, edges, aborts, gapped pixel clock, resets.
module tb_sprite_row_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [10:0] hcount;
  logic        line_start;
  logic [10:0] line_num;
  logic        sprite_on;
  logic [10:0] sprite_x;
  logic [10:0] sprite_y;
  logic [1:0]  frame_sel;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        sr_ld;
  logic [63:0] sr_data;
  logic        sr_en;
  logic        busy;

  int asserts = 0;
  int fails   = 0;

  // run statistics
  int          en_cnt, ld_cnt, ld_cycle, gap_bad, en_no_pix, overlap, en_before_ld;
  logic        en_c0, busy_c1;
  logic [5:0]  addr_c1;
  logic [63:0] ld_data;
  logic [10:0] first_hc, last_hc;

  sprite_row_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .line_start (line_start),
    .line_num   (line_num),
    .sprite_on  (sprite_on),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .frame_sel  (frame_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sr_ld      (sr_ld),
    .sr_data    (sr_data),
    .sr_en      (sr_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one clock of latency; row contents tag their own address.
  always @(posedge clk) rom_data <= {48'hA5A5_0000_0000, 10'd0, rom_addr};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_stats();
    en_cnt = 0; ld_cnt = 0; ld_cycle = -1; gap_bad = 0; en_no_pix = 0;
    overlap = 0; en_before_ld = 0; en_c0 = 1'b0; busy_c1 = 1'b0;
    addr_c1 = '0; ld_data = '0; first_hc = '0; last_hc = '0;
  endtask

  task automatic set_line(input logic [10:0] ln, input logic [10:0] sy, input logic [10:0] sx,
                          input logic on, input logic [1:0] fs);
    line_num = ln; sprite_y = sy; sprite_x = sx; sprite_on = on; frame_sel = fs;
    line_start = 1'b1;
  endtask

  // Runs from just after a rising edge; cycle 0 is the cycle that carries any line_start.
  task automatic run_cycles(input int n, input bit gapped, input int stop_en);
    for (int i = 0; i < n; i++) begin
      pix_en = gapped ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      if (i == 0) en_c0 = sr_en;
      if (i == 1) begin addr_c1 = rom_addr; busy_c1 = busy; end
      if (sr_ld) begin
        if (ld_cnt == 0) begin ld_cycle = i; ld_data = sr_data; end
        ld_cnt++;
      end
      if (sr_en) begin
        if (ld_cnt == 0) en_before_ld++;
        if (!pix_en) en_no_pix++;
        if (sr_ld) overlap++;
        if (en_cnt == 0) first_hc = hcount;
        else if (hcount != last_hc + 11'd1) gap_bad++;
        last_hc = hcount;
        en_cnt++;
      end
      @(posedge clk); #1;
      if (pix_en) hcount = hcount + 11'd1;
      line_start = 1'b0;
      if (stop_en != 0 && en_cnt >= stop_en) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b1; hcount = 11'd100; rom_data = '0;
    set_line(11'd20, 11'd15, 11'd100, 1'b1, 2'd2);
    @(posedge clk); #1;
    line_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    asserts++; if (rom_addr !== 6'd0) begin fails++; $display("FAIL reset_rom_addr: got %0d required 0", rom_addr); end
    asserts++; if (sr_ld !== 1'b0) begin fails++; $display("FAIL reset_sr_ld: got %b required 0", sr_ld); end
    asserts++; if (sr_data !== 64'd0) begin fails++; $display("FAIL reset_sr_data: got %h required 0", sr_data); end
    asserts++; if (sr_en !== 1'b0) begin fails++; $display("FAIL reset_sr_en: got %b required 0", sr_en); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_hit();
    clr_stats(); hcount = 11'd90;
    set_line(11'd20, 11'd15, 11'd100, 1'b1, 2'd2);
    run_cycles(40, 1'b0, 0);
    asserts++; if (addr_c1 !== 6'd37) begin fails++; $display("FAIL hit_rom_addr: got %0d required 37", addr_c1); end
    asserts++; if (busy_c1 !== 1'b1) begin fails++; $display("FAIL hit_busy: got %b required 1", busy_c1); end
    asserts++; if (ld_cycle != 4) begin fails++; $display("FAIL hit_ld_latency: got %0d required 4", ld_cycle); end
    asserts++; if (ld_cnt != 1) begin fails++; $display("FAIL hit_ld_count: got %0d required 1", ld_cnt); end
    asserts++; if (ld_data !== 64'hA5A5_0000_0000_0025) begin fails++; $display("FAIL hit_sr_data: got %h required a5a5000000000025", ld_data); end
    asserts++; if (en_cnt != 16) begin fails++; $display("FAIL hit_en_count: got %0d required 16", en_cnt); end
    asserts++; if (first_hc !== 11'd100 || last_hc !== 11'd115 || gap_bad != 0) begin
      fails++; $display("FAIL hit_en_window: got %0d..%0d gaps %0d required 100..115 gaps 0", first_hc, last_hc, gap_bad); end
    asserts++; if (overlap != 0 || en_before_ld != 0) begin fails++; $display("FAIL hit_ld_en_order: got overlap %0d early %0d required 0 0", overlap, en_before_ld); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL hit_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_miss();
    logic [10:0] lns [3] = '{11'd14, 11'd31, 11'd20};
    logic        ons [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0]  addr_before;
    for (int k = 0; k < 3; k++) begin
      clr_stats(); hcount = 11'd90; addr_before = rom_addr;
      set_line(lns[k], 11'd15, 11'd100, ons[k], 2'd2);
      run_cycles(30, 1'b0, 0);
      asserts++; if (addr_c1 !== addr_before) begin fails++; $display("FAIL miss%0d_rom_addr: got %0d required %0d", k, addr_c1, addr_before); end
      asserts++; if (ld_cycle != 1 || ld_cnt != 1) begin fails++; $display("FAIL miss%0d_ld: got cycle %0d count %0d required 1 1", k, ld_cycle, ld_cnt); end
      asserts++; if (ld_data !== 64'd0) begin fails++; $display("FAIL miss%0d_sr_data: got %h required 0", k, ld_data); end
      asserts++; if (en_cnt != 0 || busy_c1 !== 1'b0) begin fails++; $display("FAIL miss%0d_idle: got en %0d busy %b required 0 0", k, en_cnt, busy_c1); end
    end
  endtask

  task automatic test_edges();
    logic [10:0] lns  [2] = '{11'd30, 11'd15};
    logic [1:0]  fss  [2] = '{2'd2, 2'd1};
    logic [5:0]  addrs[2] = '{6'd47, 6'd16};
    for (int k = 0; k < 2; k++) begin
      clr_stats(); hcount = 11'd90;
      set_line(lns[k], 11'd15, 11'd100, 1'b1, fss[k]);
      run_cycles(40, 1'b0, 0);
      asserts++; if (addr_c1 !== addrs[k]) begin fails++; $display("FAIL edge%0d_rom_addr: got %0d required %0d", k, addr_c1, addrs[k]); end
      asserts++; if (ld_cycle != 4 || ld_data !== {58'h2969_4000_0000_000, addrs[k]}) begin
        fails++; $display("FAIL edge%0d_load: got cycle %0d data %h required 4 row %0d", k, ld_cycle, ld_data, addrs[k]); end
      asserts++; if (en_cnt != 16) begin fails++; $display("FAIL edge%0d_en_count: got %0d required 16", k, en_cnt); end
    end
  endtask

  task automatic test_abort();
    clr_stats(); hcount = 11'd90;
    set_line(11'd20, 11'd15, 11'd100, 1'b1, 2'd2);
    run_cycles(60, 1'b0, 7);
    asserts++; if (en_cnt != 7) begin fails++; $display("FAIL abort_pre_count: got %0d required 7", en_cnt); end
    clr_stats();
    set_line(11'd21, 11'd15, 11'd120, 1'b1, 2'd1);
    run_cycles(50, 1'b0, 0);
    asserts++; if (en_c0 !== 1'b0) begin fails++; $display("FAIL abort_en_drop: got %b required 0", en_c0); end
    asserts++; if (addr_c1 !== 6'd22) begin fails++; $display("FAIL abort_rom_addr: got %0d required 22", addr_c1); end
    asserts++; if (ld_cycle != 4 || ld_data !== 64'hA5A5_0000_0000_0016) begin
      fails++; $display("FAIL abort_load: got cycle %0d data %h required 4 a5a5000000000016", ld_cycle, ld_data); end
    asserts++; if (en_cnt != 16 || first_hc !== 11'd120 || last_hc !== 11'd135) begin
      fails++; $display("FAIL abort_reshift: got %0d pulses %0d..%0d required 16 pulses 120..135", en_cnt, first_hc, last_hc); end
  endtask

  task automatic test_gapped();
    clr_stats(); hcount = 11'd90;
    set_line(11'd20, 11'd15, 11'd100, 1'b1, 2'd3);
    run_cycles(80, 1'b1, 0);
    asserts++; if (ld_data !== 64'hA5A5_0000_0000_0035) begin fails++; $display("FAIL gap_sr_data: got %h required a5a5000000000035", ld_data); end
    asserts++; if (en_cnt != 16) begin fails++; $display("FAIL gap_en_count: got %0d required 16", en_cnt); end
    asserts++; if (en_no_pix != 0) begin fails++; $display("FAIL gap_en_without_pix: got %0d required 0", en_no_pix); end
    asserts++; if (first_hc !== 11'd100 || last_hc !== 11'd115 || gap_bad != 0) begin
      fails++; $display("FAIL gap_en_window: got %0d..%0d gaps %0d required 100..115 gaps 0", first_hc, last_hc, gap_bad); end
    asserts++; if (en_before_ld != 0 || overlap != 0) begin fails++; $display("FAIL gap_ld_en_order: got early %0d overlap %0d required 0 0", en_before_ld, overlap); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      clr_stats(); hcount = 11'd90;
      set_line(11'd20, 11'd15, 11'd100, 1'b1, 2'd3);
      if (k == 0) run_cycles(2, 1'b0, 0);
      else run_cycles(60, 1'b0, 3);
      reset = 1'b1; pix_en = 1'b1;
      @(negedge clk);
      asserts++; if (sr_en !== 1'b0) begin fails++; $display("FAIL rstmid%0d_en_in_reset: got %b required 0", k, sr_en); end
      @(posedge clk); #1;
      reset = 1'b0;
      if (pix_en) hcount = hcount + 11'd1;
      @(negedge clk);
      asserts++; if (rom_addr !== 6'd0 || sr_ld !== 1'b0 || sr_data !== 64'd0 || sr_en !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rstmid%0d_outputs: got addr %0d ld %b data %h en %b busy %b required all 0",
                          k, rom_addr, sr_ld, sr_data, sr_en, busy); end
      @(posedge clk); #1;
      if (pix_en) hcount = hcount + 11'd1;
      clr_stats();
      run_cycles(40, 1'b0, 0);
      asserts++; if (ld_cnt != 0 || en_cnt != 0) begin fails++; $display("FAIL rstmid%0d_quiet: got ld %0d en %0d required 0 0", k, ld_cnt, en_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hcount = '0; line_start = 1'b0; line_num = '0;
    sprite_on = 1'b0; sprite_x = '0; sprite_y = '0; frame_sel = '0;
    clr_stats();
    test_reset();
    test_basic_hit();
    test_miss();
    test_edges();
    test_abort();
    test_gapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
